// File: rtl/reg_file_32x32_if.sv
// Register-file access bundle: one write port (we/wa/wd) and two read ports (ra/rd).
// The master side is decode/writeback. The slave side is the register file.
interface reg_file_32x32_if;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;

  modport master (
    output we, wa, wd, ra1, ra2,
    input  rd1, rd2
  );

  modport slave (
    input  we, wa, wd, ra1, ra2,
    output rd1, rd2
  );
endinterface

// File: rtl/reg_file_32x32.sv
// RISC-V integer register file x0..x31: one synchronous write port and two combinational read ports.
// x0 is hardwired to zero. An optional write-first bypass forwards wd to a read port in the same cycle.
module mux_32to1 (
  input  logic [31:0] in_data [32],
  input  logic [4:0]  sel,
  output logic [31:0] out_data
);
  assign out_data = in_data[sel];
endmodule

module reg_file_32x32 #(
  parameter bit          BYPASS    = 1'b1,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_file_32x32_if.slave  bus
);

  // A write may only commit once a falling clk edge has seen rst_n high.
  // As a result, the clk edge on which reset is released can never be a write edge.
  logic wr_arm;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) wr_arm <= 1'b0;
    else        wr_arm <= 1'b1;
  end

  logic commit;
  assign commit = wr_arm & bus.we & (bus.wa != 5'd0);

  logic [31:1] wen;

  always_comb begin
    wen = '0;
    for (int i = 1; i < 32; i++) begin
      wen[i] = commit && (bus.wa == 5'(i));
    end
  end

  logic [31:0] bank [32];
  assign bank[0] = 32'h0;

  for (genvar g = 1; g < 32; g++) begin : g_reg
    logic [31:0] q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      q <= RESET_VAL;
      else if (wen[g]) q <= bus.wd;
    end
    assign bank[g] = q;
  end

  logic [31:0] bank_rd1;
  logic [31:0] bank_rd2;

  mux_32to1 u_mux_rd1 (
    .in_data  (bank),
    .sel      (bus.ra1),
    .out_data (bank_rd1)
  );

  mux_32to1 u_mux_rd2 (
    .in_data  (bank),
    .sel      (bus.ra2),
    .out_data (bank_rd2)
  );

  // Bypass only fires when the write will actually commit.
  // This keeps it off for x0 and while reset is asserted.
  logic hit1;
  logic hit2;
  assign hit1 = BYPASS && commit && (bus.wa == bus.ra1);
  assign hit2 = BYPASS && commit && (bus.wa == bus.ra2);

  assign bus.rd1 = hit1 ? bus.wd : bank_rd1;
  assign bus.rd2 = hit2 ? bus.wd : bank_rd2;

endmodule

// File: doc/reg_file_32x32.md
Name: reg_file_32x32

Overview:
32-entry x 32-bit integer register file for the single- and multi-cycle RISC-V cores. It holds the architectural registers x0..x31 and provides one synchronous write port and two combinational read ports. Each read port is one mux_32to1 instance fed directly by the register bank. It sits between the decode stage (register addresses) and the ALU/operand muxes, with writeback driving the write port.

Parameters:
BYPASS, 1, 1 = a same-cycle write to the address being read is forwarded to the read output (write-first); 0 = the read returns the pre-write value.
RESET_VAL, 32'h0000_0000, value loaded into x1..x31 on reset.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
we  input  1  write enable, sampled on the rising edge of clk
wa  input  5  write address
wd  input  32  write data
ra1  input  5  read address, port 1
ra2  input  5  read address, port 2
rd1  output  32  read data, port 1
rd2  output  32  read data, port 2

Behaviour:
- Clocking and reset:
  - Single clock, clk. Reset is asynchronous and active-low on rst_n.
  - While rst_n=0, x1..x31 are forced to RESET_VAL immediately, without waiting for a clock edge. Any write presented during reset is discarded.
  - The rst_n release edge coinciding with a clk edge is not a write edge: a write is accepted only on a clk rising edge where rst_n=1.
- Storage:
  - 31 physical 32-bit registers, x1..x31.
  - x0 has no storage and always reads 32'h0.
- Write:
  - On a clk rising edge with rst_n=1, we=1 and wa!=0: x[wa] <= wd.
  - A write with wa=0 is silently dropped.
  - With we=0, nothing changes.
  - At most one register changes per cycle.
- Read:
  - Purely combinational, 0-cycle latency.
  - rd1 = x[ra1] and rd2 = x[ra2], each selected by a mux_32to1 instance with in0 tied to 32'h0.
  - Both ports may address the same register at the same time; both return the same value.
- Bypass, when BYPASS=1:
  - If we=1, wa!=0 and wa==ra1, then rd1=wd in that cycle. The same rule applies to rd2 with ra2.
  - If wa==0, there is no bypass, so reading x0 always returns 0.
  - The bypass is combinational from we, wa, wd and the read addresses to rd1/rd2.
  - With BYPASS=0, rd reflects the old value until the next edge.
- During reset: rd1/rd2 return RESET_VAL for addresses 1..31 and 0 for address 0. The bypass is suppressed while rst_n=0.
- Outputs are not registered. With rst_n=0, rd1 and rd2 settle to the reset-time values above.
- No X propagation: every address 0..31 decodes, so there is no default/undefined select.
- Implementation shape: a write-address decoder of 31 one-hot enables, 31 enabled flops with async clear, two mux_32to1 instances, and two bypass comparators/muxes.

Test Plan:
- Reset: hold rst_n=0, sweep ra1/ra2 over 0..31 -> rd1=rd2=32'h0 for every address. Deassert, then write x5=32'hDEAD_BEEF and assert rst_n=0 between clock edges -> rd of x5 returns 0 immediately, with no edge needed.
- Write/read all: write x[i]=32'h1000_0000+i for i=1..31, one per cycle, then read pairs (ra1=i, ra2=31-i) -> rd1=32'h1000_0000+i and rd2=32'h1000_0000+(31-i); ra=0 returns 0.
- x0 immutability: we=1, wa=0, wd=32'hFFFF_FFFF for 3 cycles with ra1=0 -> rd1=0 throughout, including the write cycle (no bypass), and no other register changes.
- Bypass (BYPASS=1): x7 holds 32'h1111_1111; drive we=1, wa=7, wd=32'h2222_2222, ra1=ra2=7 -> rd1=rd2=32'h2222_2222 before the edge and after it. With BYPASS=0, rd1=32'h1111_1111 before the edge and 32'h2222_2222 after.
- we gating: we=0, wa=3, wd=32'hABCD_0123 for 2 edges -> x3 is unchanged. Then we=1 for exactly 1 edge -> x3=32'hABCD_0123, and the neighbours x2 and x4 are unchanged.
- Reset vs write edge: rst_n rises on the same edge as we=1, wa=9, wd=32'h5 -> x9 stays RESET_VAL. The same write presented on the next edge -> x9=32'h5.
